intr_arbiter: RTL and testbench

Interrupt controller that shares the CPU's single INTR input among N_SRC edge-triggered sources (buttons, timers, peripherals). It latches request edges into a pending register and grants one source at a time. For each grant it drives a fixed-length INTR pulse and presents the granted source ID on a port the CPU reads in its ISR. It holds further grants until the CPU signals end-of-interrupt. It sits between the peripheral request lines and the CPU interrupt pin, in place of a per-source pulse FSM.

---
 rtl/intr_pkg.sv | 13 +
 rtl/intr_prio_sel.sv | 38 +++
 rtl/intr_arbiter.sv | 115 +++++++++++
 tb/tb_intr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared types and default sizing for the interrupt arbiter.
package intr_pkg;

    localparam int unsigned INTR_N_SRC_DEF     = 4;
    localparam int unsigned INTR_PULSE_LEN_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_e;

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational priority selector: first set bit of req searching upward from start, wrapping.
module intr_prio_sel
    import intr_pkg::*;
#(
    parameter  int unsigned N_SRC = INTR_N_SRC_DEF,
    localparam int unsigned IDW   = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDW-1:0]   start,
    output logic             valid,
    output logic [IDW-1:0]   winner
);

    localparam logic [IDW:0] N_SRC_W = (IDW+1)'(N_SRC);

    logic [N_SRC-1:0] rot;
    logic [IDW-1:0]   off;
    logic [IDW:0]     sum;

    // Rotate so bit 0 is the start index, pick the lowest set bit, then rotate the offset back.
    always_comb begin
        rot    = N_SRC'({req, req} >> start);
        valid  = 1'b0;
        off    = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (rot[i] && !valid) begin
                valid = 1'b1;
                off   = IDW'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= N_SRC_W) begin
            sum = sum - N_SRC_W;
        end
        winner = sum[IDW-1:0];
    end

endmodule

// File: rtl/intr_arbiter.sv
// Shares one CPU interrupt pin among N_SRC edge-triggered sources, one grant per EOI.
// Define INTR_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module intr_arbiter
    import intr_pkg::*;
#(
    parameter  int unsigned N_SRC     = INTR_N_SRC_DEF,
    parameter  int unsigned PULSE_LEN = INTR_PULSE_LEN_DEF,
    localparam int unsigned IDW       = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq,
    input  logic [N_SRC-1:0] mask,
    input  logic             intr_en,
    input  logic             eoi,
    output logic             intr,
    output logic [IDW-1:0]   id,
    output logic [N_SRC-1:0] pend,
    output logic             busy
);

    localparam int unsigned     CNTW     = $clog2(PULSE_LEN + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(PULSE_LEN - 1);

    intr_state_e      state;
    logic [CNTW-1:0]  cnt;
    logic [N_SRC-1:0] prev_irq;
    logic             armed;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] elig;
    logic [IDW-1:0]   start;
    logic [IDW-1:0]   winner;
    logic             sel_valid;
    logic             grant;

`ifdef INTR_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr;

    // Search begins one past the most recent grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == IDW'(N_SRC - 1)) ? '0 : winner + IDW'(1);
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    // Levels already high when reset releases are not requests; armed masks that first cycle.
    assign rise  = irq & ~prev_irq & {N_SRC{armed}};
    assign elig  = pend & mask;
    assign grant = (state == ST_IDLE) && intr_en && sel_valid;
    assign clr   = grant ? (N_SRC'(1) << winner) : '0;

    intr_prio_sel #(.N_SRC(N_SRC)) u_sel (
        .req    (elig),
        .start  (start),
        .valid  (sel_valid),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            prev_irq <= '0;
            armed    <= 1'b0;
            pend     <= '0;
            id       <= '0;
            intr     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            prev_irq <= irq;
            armed    <= 1'b1;
            // A new edge in the grant cycle wins over the grant's clear.
            pend     <= (pend & ~clr) | rise;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state <= ST_PULSE;
                        id    <= winner;
                        cnt   <= CNT_LOAD;
                        intr  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_SERVICE;
                        intr  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    intr  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter; expected grant IDs are queued at stimulus time and popped per grant.
module tb_intr_arbiter;

    localparam int unsigned N_SRC     = 4;
    localparam int unsigned PULSE_LEN = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       intr_en;
    logic       eoi;
    logic       intr;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    intr_arbiter #(.N_SRC(N_SRC), .PULSE_LEN(PULSE_LEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq     (irq),
        .mask    (mask),
        .intr_en (intr_en),
        .eoi     (eoi),
        .intr    (intr),
        .id      (id),
        .pend    (pend),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic no_intr(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (intr !== 1'b0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'(1'b0));
    endtask

    // Wait for a grant, check its ID against the queue, measure the pulse, then acknowledge.
    task automatic serve(input string tag, input bit eoi_mid);
        int n;
        int len;
        logic [1:0] e;
        n = 0;
        while (intr !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        check({tag, "_intr"}, 32'(intr), 32'(1'b1));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        check({tag, "_id"}, 32'(id), 32'(e));
        check({tag, "_busy_grant"}, 32'(busy), 32'(1'b1));
        len = 0;
        while (intr === 1'b1 && len < 64) begin
            len++;
            eoi = eoi_mid && (len == 2);
            tick();
        end
        eoi = 1'b0;
        check({tag, "_pulse_len"}, 32'(len), 32'(PULSE_LEN));
        tick();
        tick();
        check({tag, "_busy_wait"}, 32'(busy), 32'(1'b1));
        check({tag, "_id_hold"}, 32'(id), 32'(e));
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check({tag, "_busy_eoi"}, 32'(busy), 32'(1'b0));
    endtask

    initial begin
        reset_n = 1'b0;
        irq     = 4'hF;
        mask    = 4'hF;
        intr_en = 1'b1;
        eoi     = 1'b0;
        repeat (3) tick();
        check("rst_intr", 32'(intr), 32'(1'b0));
        check("rst_pend", 32'(pend), 32'(4'h0));
        check("rst_id",   32'(id),   32'(2'd0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        reset_n = 1'b1;
        no_intr("rst_irq_held_no_grant", 8);
        check("rst_pend_after", 32'(pend), 32'(4'h0));
        irq = 4'h0;
        tick();

        // Single request on source 2
        irq = 4'b0100;
        tick();
        check("single_pend", 32'(pend), 32'(4'b0100));
        check("single_no_early", 32'(intr), 32'(1'b0));
        exp_q.push_back(2'd2);
        tick();
        check("single_latency", 32'(intr), 32'(1'b1));
        check("single_pend_clr", 32'(pend), 32'(4'h0));
        serve("single", 1'b0);
        irq = 4'h0;
        tick();

        // Simultaneous requests on sources 1 and 3, twice
`ifdef INTR_ROUND_ROBIN_EN
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
`else
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
`endif
        for (int r = 0; r < 2; r++) begin
            irq = 4'b1010;
            tick();
            check("sim_pend", 32'(pend), 32'(4'b1010));
            serve("sim_first", 1'b0);
            serve("sim_second", 1'b0);
            irq = 4'h0;
            tick();
        end

        // Masked pending bit waits for its mask
        mask = 4'b1110;
        irq  = 4'b0001;
        tick();
        check("mask_pend", 32'(pend), 32'(4'b0001));
        no_intr("mask_blocks", 4);
        check("mask_pend_kept", 32'(pend), 32'(4'b0001));
        mask = 4'hF;
        exp_q.push_back(2'd0);
        tick();
        check("mask_rise_grant", 32'(intr), 32'(1'b1));
        serve("mask", 1'b0);
        irq = 4'h0;
        tick();

        // Global enable low blocks grants, pending retained
        intr_en = 1'b0;
        irq     = 4'b0100;
        no_intr("en_blocks", 5);
        check("en_pend_kept", 32'(pend), 32'(4'b0100));
        intr_en = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        check("en_grant", 32'(intr), 32'(1'b1));
        serve("en", 1'b0);
        irq = 4'h0;
        tick();

        // EOI during the pulse is ignored
        irq = 4'b1000;
        exp_q.push_back(2'd3);
        tick();
        serve("eoi_mid", 1'b1);
        irq = 4'h0;
        tick();

        // New edge on the granted source in its grant cycle keeps it pending
        intr_en = 1'b0;
        irq     = 4'b0010;
        tick();
        irq = 4'h0;
        tick();
        intr_en = 1'b1;
        irq     = 4'b0010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        tick();
        check("regrant_intr", 32'(intr), 32'(1'b1));
        check("regrant_pend_set", 32'(pend), 32'(4'b0010));
        serve("regrant_a", 1'b0);
        serve("regrant_b", 1'b0);
        check("regrant_pend_clr", 32'(pend), 32'(4'h0));
        irq = 4'h0;
        tick();

        // Reset on the third pulse cycle
        irq = 4'b0100;
        tick();
        tick();
        check("midrst_c1", 32'(intr), 32'(1'b1));
        tick();
        tick();
        check("midrst_c3", 32'(intr), 32'(1'b1));
        reset_n = 1'b0;
        irq     = 4'b0101;
        tick();
        check("midrst_intr", 32'(intr), 32'(1'b0));
        check("midrst_busy", 32'(busy), 32'(1'b0));
        check("midrst_pend", 32'(pend), 32'(4'h0));
        check("midrst_id",   32'(id),   32'(2'd0));
        reset_n = 1'b1;
        irq     = 4'h0;
        no_intr("midrst_quiet", 10);
        check("midrst_busy_after", 32'(busy), 32'(1'b0));

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
